// File: rtl/player2_ctrl_pkg.sv
// Shared types and screen geometry for the player-2 controller.
package player2_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RIGHT1 = 3'd1,
        RIGHT2 = 3'd2,
        LEFT1  = 3'd3,
        LEFT2  = 3'd4
    } State;

    typedef enum logic [1:0] {
        DIR_NONE = 2'd0,
        DIR_R    = 2'd1,
        DIR_L    = 2'd2
    } dir_t;

    localparam int PLAYER_W  = 40;
    localparam int SCREEN_W  = 1024;
    localparam int X_MAX_DEF = SCREEN_W - PLAYER_W;

    // Opposing buttons cancel each other out.
    function automatic dir_t decode_dir(input logic left, input logic right);
        if (left && !right)
            return DIR_L;
        if (right && !left)
            return DIR_R;
        return DIR_NONE;
    endfunction

endpackage

// File: rtl/player2_jump.sv
// Vertical jump physics for player 2, advanced once per frame tick.
// Only built when PLAYER2_JUMP_EN is defined.
`ifdef PLAYER2_JUMP_EN
module player2_jump #(
    parameter int JUMP_V0 = 12,
    parameter int GRAVITY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic        btn_jump,
    output logic [11:0] ypos,
    output logic        airborne
);

    logic signed [7:0]  vy;
    logic signed [13:0] y_next;

    assign y_next = $signed({2'b00, ypos}) + $signed({{6{vy[7]}}, vy});

    always_ff @(posedge clk) begin
        if (rst) begin
            ypos     <= '0;
            vy       <= '0;
            airborne <= 1'b0;
        end else if (tick) begin
            if (!airborne) begin
                // Launch tick leaves ypos alone; landing tick cannot relaunch.
                if (btn_jump) begin
                    vy       <= 8'(JUMP_V0);
                    airborne <= 1'b1;
                end
            end else if (y_next <= 14'sd0) begin
                ypos     <= '0;
                vy       <= '0;
                airborne <= 1'b0;
            end else begin
                ypos <= y_next[11:0];
                vy   <= vy - 8'(GRAVITY);
            end
        end
    end

endmodule
`endif

// File: rtl/player2_ctrl.sv
// Player-2 per-frame motion/animation controller (vsync edge, walk FSM, xpos).
// Define PLAYER2_JUMP_EN to enable jump physics; otherwise ypos is held at 0.
module player2_ctrl
    import player2_ctrl_pkg::*;
#(
    parameter int X_INIT      = 100,
    parameter int X_MIN       = 0,
    parameter int X_MAX       = X_MAX_DEF,
    parameter int STEP        = 4,
    parameter int ANIM_FRAMES = 8,
    parameter int JUMP_V0     = 12,
    parameter int GRAVITY     = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vsync,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_jump,
    output logic [11:0] xpos_player2,
    output logic [11:0] ypos_player2,
    output State        state,
    output logic        frame_tick
);

    localparam int CNT_W = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1;

    logic             vsync_q;
    logic [CNT_W-1:0] anim_cnt;
    dir_t             dir;
    logic             anim_last;
    logic [12:0]      x_inc;
    logic [11:0]      x_right;
    logic [11:0]      x_left;

    assign dir       = decode_dir(btn_left, btn_right);
    assign anim_last = (anim_cnt == CNT_W'(ANIM_FRAMES - 1));
    assign x_inc     = {1'b0, xpos_player2} + 13'(STEP);
    assign x_right   = (x_inc > 13'(X_MAX)) ? 12'(X_MAX) : x_inc[11:0];
    // Compare before subtracting so the left step can never wrap below zero.
    assign x_left    = ({1'b0, xpos_player2} < 13'(X_MIN + STEP)) ? 12'(X_MIN)
                                                                  : xpos_player2 - 12'(STEP);

    always_ff @(posedge clk) begin
        if (rst) begin
            vsync_q      <= 1'b0;
            frame_tick   <= 1'b0;
            xpos_player2 <= 12'(X_INIT);
            state        <= IDLE;
            anim_cnt     <= '0;
        end else begin
            vsync_q    <= vsync;
            frame_tick <= vsync & ~vsync_q;
            if (frame_tick) begin
                unique case (dir)
                    DIR_R: begin
                        xpos_player2 <= x_right;
                        if (state == RIGHT1 || state == RIGHT2) begin
                            if (anim_last) begin
                                state    <= (state == RIGHT1) ? RIGHT2 : RIGHT1;
                                anim_cnt <= '0;
                            end else begin
                                anim_cnt <= anim_cnt + 1'b1;
                            end
                        end else begin
                            state    <= RIGHT1;
                            anim_cnt <= '0;
                        end
                    end
                    DIR_L: begin
                        xpos_player2 <= x_left;
                        if (state == LEFT1 || state == LEFT2) begin
                            if (anim_last) begin
                                state    <= (state == LEFT1) ? LEFT2 : LEFT1;
                                anim_cnt <= '0;
                            end else begin
                                anim_cnt <= anim_cnt + 1'b1;
                            end
                        end else begin
                            state    <= LEFT1;
                            anim_cnt <= '0;
                        end
                    end
                    default: begin
                        state    <= IDLE;
                        anim_cnt <= '0;
                    end
                endcase
            end
        end
    end

`ifdef PLAYER2_JUMP_EN
    logic airborne;
    logic unused_airborne;

    player2_jump #(
        .JUMP_V0 (JUMP_V0),
        .GRAVITY (GRAVITY)
    ) u_jump (
        .clk      (clk),
        .rst      (rst),
        .tick     (frame_tick),
        .btn_jump (btn_jump),
        .ypos     (ypos_player2),
        .airborne (airborne)
    );

    assign unused_airborne = airborne;
`else
    localparam int unused_jump_params = JUMP_V0 + GRAVITY;
    logic unused_btn_jump;

    assign unused_btn_jump = btn_jump;
    assign ypos_player2    = '0;
`endif

endmodule
